// File: rtl/psg_bus_writer_if.sv
// Request handshake plus tone-generator write bus (A0/WR/D) for psg_bus_writer.
// master = sequencer/CPU side, slave = the writer block itself.
interface psg_bus_writer_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqKind;
  logic [1:0]  reqCh;
  logic [11:0] reqData;
  logic        reqErr;
  logic        a0;
  logic        wr;
  logic [3:0]  d;
  logic        busy;

  modport master (
    output reqValid, reqKind, reqCh, reqData,
    input  reqReady, reqErr, a0, wr, d, busy
  );

  modport slave (
    input  reqValid, reqKind, reqCh, reqData,
    output reqReady, reqErr, a0, wr, d, busy
  );
endinterface

// File: rtl/psg_bus_writer.sv
// Turns tone-period / enable-mask requests into address+data nibble strobes for the PSG core.
// Optional PSG_SKIP_UNCHANGED_EN: shadow registers suppress writes of unchanged nibbles.
module psg_bus_writer #(
  parameter int unsigned GAP = 1
) (
  input logic             clk,
  input logic             rst_n,
  psg_bus_writer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DROP,
    S_ADDR,
    S_ADDR_GAP,
    S_DATA,
    S_DATA_GAP
  } state_t;

  localparam logic [3:0] GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);
  localparam logic [3:0] EN_ADDR  = 4'hF;

  state_t      state, stateNext;
  logic [3:0]  gapCnt, gapCntNext;
  logic [1:0]  nibIdx, nibIdxNext;
  logic [2:0]  pend, pendNext, pendLeft;
  logic        kindQ, kindNext;
  logic [1:0]  chQ, chNext;
  logic [11:0] dataQ, dataNext;
  logic        a0Q, a0Next;
  logic        wrQ, wrNext;
  logic [3:0]  dQ, dNext;
  logic        readyQ, readyNext;
  logic        busyQ;
  logic        errQ, errNext;
  logic [2:0]  dirty;
  logic [3:0]  toneBase, addrNext, nibNext;

  function automatic logic [1:0] firstSet(input logic [2:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else           return 2'd2;
  endfunction

`ifdef PSG_SKIP_UNCHANGED_EN
  logic [3:0] shadowTone [9];
  logic [8:0] toneValid;
  logic [2:0] shadowEn;
  logic       enValid;
  logic [3:0] reqBase, chkIdx, curIdx;

  always_comb begin
    dirty   = '0;
    chkIdx  = '0;
    reqBase = 4'(bus.reqCh) * 4'd3;
    if (bus.reqKind) begin
      dirty[0] = !enValid || (shadowEn != bus.reqData[2:0]);
    end else if (bus.reqCh != 2'd3) begin
      for (int unsigned i = 0; i < 3; i++) begin
        chkIdx        = reqBase + 4'(i);
        dirty[2'(i)]  = !toneValid[chkIdx] ||
                        (shadowTone[chkIdx] != bus.reqData[4'(i) * 4'd4 +: 4]);
      end
    end
  end

  assign curIdx = 4'(chQ) * 4'd3 + 4'(nibIdx);

  // Shadow tracks what the core holds: updated on the edge that samples the data strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toneValid <= '0;
      enValid   <= 1'b0;
    end else if (state == S_DATA) begin
      if (kindQ) enValid           <= 1'b1;
      else       toneValid[curIdx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_DATA) begin
      if (kindQ) shadowEn           <= dataQ[2:0];
      else       shadowTone[curIdx] <= dataQ[{nibIdx, 2'b00} +: 4];
    end
  end
`else
  always_comb dirty = bus.reqKind ? 3'b001 : 3'b111;
`endif

  always_comb begin
    stateNext  = state;
    gapCntNext = gapCnt;
    nibIdxNext = nibIdx;
    pendNext   = pend;
    pendLeft   = pend;
    kindNext   = kindQ;
    chNext     = chQ;
    dataNext   = dataQ;
    errNext    = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.reqValid) begin
          kindNext = bus.reqKind;
          chNext   = bus.reqCh;
          dataNext = bus.reqData;
          // Illegal or fully-clean requests still spend one not-ready cycle in DROP.
          if (!bus.reqKind && bus.reqCh == 2'd3) begin
            errNext   = 1'b1;
            stateNext = S_DROP;
          end else if (dirty == '0) begin
            stateNext = S_DROP;
          end else begin
            pendNext   = dirty;
            nibIdxNext = firstSet(dirty);
            stateNext  = S_ADDR;
          end
        end
      end
      S_DROP: stateNext = S_IDLE;
      S_ADDR: begin
        gapCntNext = '0;
        stateNext  = (GAP == 0) ? S_DATA : S_ADDR_GAP;
      end
      S_ADDR_GAP: begin
        if (gapCnt == GAP_LAST) stateNext = S_DATA;
        else                    gapCntNext = gapCnt + 4'd1;
      end
      S_DATA: begin
        gapCntNext = '0;
        pendLeft   = pend & ~(3'b001 << nibIdx);
        pendNext   = pendLeft;
        if (GAP != 0) begin
          stateNext = S_DATA_GAP;
        end else if (pendLeft != '0) begin
          nibIdxNext = firstSet(pendLeft);
          stateNext  = S_ADDR;
        end else begin
          stateNext = S_IDLE;
        end
      end
      S_DATA_GAP: begin
        if (gapCnt == GAP_LAST) begin
          if (pend != '0) begin
            nibIdxNext = firstSet(pend);
            stateNext  = S_ADDR;
          end else begin
            stateNext = S_IDLE;
          end
        end else begin
          gapCntNext = gapCnt + 4'd1;
        end
      end
      default: stateNext = S_IDLE;
    endcase

    // Outputs are registered from the next state so the first strobe lands in cycle 0.
    toneBase  = 4'(chNext) * 4'd3;
    addrNext  = kindNext ? EN_ADDR : toneBase + 4'd1 + 4'(nibIdxNext);
    nibNext   = kindNext ? {1'b0, dataNext[2:0]} : dataNext[{nibIdxNext, 2'b00} +: 4];
    wrNext    = 1'b0;
    a0Next    = a0Q;
    dNext     = dQ;
    if (stateNext == S_ADDR) begin
      wrNext = 1'b1;
      a0Next = 1'b0;
      dNext  = addrNext;
    end else if (stateNext == S_DATA) begin
      wrNext = 1'b1;
      a0Next = 1'b1;
      dNext  = nibNext;
    end
    readyNext = (stateNext == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      gapCnt <= '0;
      nibIdx <= '0;
      pend   <= '0;
      kindQ  <= 1'b0;
      chQ    <= '0;
      dataQ  <= '0;
      a0Q    <= 1'b0;
      wrQ    <= 1'b0;
      dQ     <= '0;
      readyQ <= 1'b1;
      busyQ  <= 1'b0;
      errQ   <= 1'b0;
    end else begin
      state  <= stateNext;
      gapCnt <= gapCntNext;
      nibIdx <= nibIdxNext;
      pend   <= pendNext;
      kindQ  <= kindNext;
      chQ    <= chNext;
      dataQ  <= dataNext;
      a0Q    <= a0Next;
      wrQ    <= wrNext;
      dQ     <= dNext;
      readyQ <= readyNext;
      busyQ  <= !readyNext;
      errQ   <= errNext;
    end
  end

  assign bus.reqReady = readyQ;
  assign bus.busy     = busyQ;
  assign bus.reqErr   = errQ;
  assign bus.a0       = a0Q;
  assign bus.wr       = wrQ;
  assign bus.d        = dQ;

endmodule

// File: tb/tb_psg_bus_writer.sv
// Bench for psg_bus_writer: GAP=0 and GAP=1 instances, strobe scoreboard, request table.
`timescale 1ns/1ps
module tb_psg_bus_writer;

  logic clk = 1'b0;
  logic rstN0 = 1'b0;
  logic rstN1 = 1'b0;
  always #5 clk = ~clk;

  psg_bus_writer_if bus0();
  psg_bus_writer_if bus1();

  psg_bus_writer #(.GAP(0)) dut0 (.clk(clk), .rst_n(rstN0), .bus(bus0.slave));
  psg_bus_writer #(.GAP(1)) dut1 (.clk(clk), .rst_n(rstN1), .bus(bus1.slave));

  typedef struct packed {
    logic       a0;
    logic [3:0] d;
    int         cyc;
  } strobe_t;

  typedef struct {
    int          s;
    logic        kind;
    logic [1:0]  ch;
    logic [11:0] data;
    int          n;
    logic [11:0] addrs;
    logic [11:0] nibs;
    logic        err;
  } vec_t;

  strobe_t exp0[$];
  strobe_t exp1[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobes0 = 0;
  int strobes1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    strobe_t e;
    if (bus0.wr === 1'b1) begin
      strobes0++;
      if (exp0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0 strobe: got unexpected a0=%0d d=%0h expected none (cycle %0d)",
                 bus0.a0, bus0.d, cyc);
      end else begin
        e = exp0.pop_front();
        cmp("dut0 strobe a0", 32'(bus0.a0), 32'(e.a0));
        cmp("dut0 strobe d", 32'(bus0.d), 32'(e.d));
        cmp("dut0 strobe cycle", cyc, e.cyc);
      end
    end
    if (bus1.wr === 1'b1) begin
      strobes1++;
      if (exp1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1 strobe: got unexpected a0=%0d d=%0h expected none (cycle %0d)",
                 bus1.a0, bus1.d, cyc);
      end else begin
        e = exp1.pop_front();
        cmp("dut1 strobe a0", 32'(bus1.a0), 32'(e.a0));
        cmp("dut1 strobe d", 32'(bus1.d), 32'(e.d));
        cmp("dut1 strobe cycle", cyc, e.cyc);
      end
    end
  end

  function automatic logic rdy(input int s);
    return (s != 0) ? bus1.reqReady : bus0.reqReady;
  endfunction

  function automatic logic errOf(input int s);
    return (s != 0) ? bus1.reqErr : bus0.reqErr;
  endfunction

  function automatic logic busyOf(input int s);
    return (s != 0) ? bus1.busy : bus0.busy;
  endfunction

  task automatic drive(input int s, input logic v, input logic k, input logic [1:0] c,
                       input logic [11:0] dt);
    if (s != 0) begin
      bus1.reqValid = v; bus1.reqKind = k; bus1.reqCh = c; bus1.reqData = dt;
    end else begin
      bus0.reqValid = v; bus0.reqKind = k; bus0.reqCh = c; bus0.reqData = dt;
    end
  endtask

  task automatic pushStrobe(input int s, input logic a0, input logic [3:0] d, input int c);
    strobe_t e;
    e.a0 = a0; e.d = d; e.cyc = c;
    if (s != 0) exp1.push_back(e);
    else        exp0.push_back(e);
  endtask

  task automatic resetCheck(input int s);
    if (s != 0) begin
      cmp("dut1 reset a0", 32'(bus1.a0), 0);
      cmp("dut1 reset wr", 32'(bus1.wr), 0);
      cmp("dut1 reset d", 32'(bus1.d), 0);
      cmp("dut1 reset ready", 32'(bus1.reqReady), 1);
      cmp("dut1 reset err", 32'(bus1.reqErr), 0);
      cmp("dut1 reset busy", 32'(bus1.busy), 0);
    end else begin
      cmp("dut0 reset a0", 32'(bus0.a0), 0);
      cmp("dut0 reset wr", 32'(bus0.wr), 0);
      cmp("dut0 reset d", 32'(bus0.d), 0);
      cmp("dut0 reset ready", 32'(bus0.reqReady), 1);
      cmp("dut0 reset err", 32'(bus0.reqErr), 0);
      cmp("dut0 reset busy", 32'(bus0.busy), 0);
    end
  endtask

  // Issues one request, queues its expected strobes and checks READY/ERR/BUSY each cycle.
  task automatic runReq(input int s, input logic kind, input logic [1:0] ch,
                        input logic [11:0] data, input int n, input logic [11:0] addrs,
                        input logic [11:0] nibs, input logic err);
    int per, readyAt, acc;
    bit got;
    per     = (s != 0) ? 2 : 1;
    readyAt = (n == 0) ? 1 : n * 2 * per;
    got     = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (rdy(s) === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL dut%0d ready wait: got ready=0 for 100 cycles expected ready=1", s);
      return;
    end
    drive(s, 1'b1, kind, ch, data);
    @(posedge clk);
    #1;
    acc = cyc;
    for (int k = 0; k < n; k++) begin
      pushStrobe(s, 1'b0, addrs[4*k +: 4], acc + 2 * per * k);
      pushStrobe(s, 1'b1, nibs[4*k +: 4], acc + 2 * per * k + per);
    end
    drive(s, 1'b0, ~kind, ~ch, ~data);
    for (int c = 0; c <= readyAt; c++) begin
      @(negedge clk);
      cmp($sformatf("dut%0d ready c%0d", s, c), 32'(rdy(s)), 32'(c == readyAt));
      cmp($sformatf("dut%0d err c%0d", s, c), 32'(errOf(s)), 32'(err && c == 0));
      cmp($sformatf("dut%0d busy c%0d", s, c), 32'(busyOf(s)), 32'(c != readyAt));
    end
    cmp($sformatf("dut%0d pending strobes", s),
        (s != 0) ? exp1.size() : exp0.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int snap, prevAcc, acc;
    bit got;
    logic [11:0] bbData[4];

    vecs[0] = '{s: 1, kind: 1'b0, ch: 2'd1, data: 12'hABC, n: 3, addrs: 12'h654, nibs: 12'hABC, err: 1'b0};
    vecs[1] = '{s: 1, kind: 1'b0, ch: 2'd0, data: 12'hF0E, n: 3, addrs: 12'h321, nibs: 12'hF0E, err: 1'b0};
    vecs[2] = '{s: 1, kind: 1'b1, ch: 2'd3, data: 12'hFF7, n: 1, addrs: 12'h00F, nibs: 12'h007, err: 1'b0};
    vecs[3] = '{s: 1, kind: 1'b0, ch: 2'd3, data: 12'h123, n: 0, addrs: 12'h000, nibs: 12'h000, err: 1'b1};
    vecs[4] = '{s: 0, kind: 1'b1, ch: 2'd0, data: 12'h005, n: 1, addrs: 12'h00F, nibs: 12'h005, err: 1'b0};
    vecs[5] = '{s: 0, kind: 1'b0, ch: 2'd2, data: 12'h9A1, n: 3, addrs: 12'h987, nibs: 12'h9A1, err: 1'b0};
    vecs[6] = '{s: 0, kind: 1'b1, ch: 2'd1, data: 12'h00A, n: 1, addrs: 12'h00F, nibs: 12'h002, err: 1'b0};
    vecs[7] = '{s: 0, kind: 1'b0, ch: 2'd3, data: 12'hFFF, n: 0, addrs: 12'h000, nibs: 12'h000, err: 1'b1};
    vecs[8] = '{s: 0, kind: 1'b0, ch: 2'd0, data: 12'h0F3, n: 3, addrs: 12'h321, nibs: 12'h0F3, err: 1'b0};
    bbData = '{12'h555, 12'h666, 12'h777, 12'h888};

    drive(0, 1'b0, 1'b0, 2'd0, 12'h000);
    drive(1, 1'b0, 1'b0, 2'd0, 12'h000);
    repeat (3) @(negedge clk);
    resetCheck(0);
    resetCheck(1);
    rstN0 = 1'b1;
    rstN1 = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      runReq(vecs[i].s, vecs[i].kind, vecs[i].ch, vecs[i].data, vecs[i].n,
             vecs[i].addrs, vecs[i].nibs, vecs[i].err);

    // Reset during the cycle-3 data strobe of a GAP=0 tone write.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 2'd1, 12'h3C5);
    @(posedge clk);
    #1;
    acc = cyc;
    pushStrobe(0, 1'b0, 4'd4, acc);
    pushStrobe(0, 1'b1, 4'h5, acc + 1);
    pushStrobe(0, 1'b0, 4'd5, acc + 2);
    drive(0, 1'b0, 1'b0, 2'd0, 12'h000);
    repeat (3) @(posedge clk);
    #1;
    cmp("midreset wr before", 32'(bus0.wr), 1);
    cmp("midreset d before", 32'(bus0.d), 32'hC);
    rstN0 = 1'b0;
    #1;
    resetCheck(0);
    @(negedge clk);
    @(negedge clk);
    cmp("midreset pending strobes", exp0.size(), 0);
    rstN0 = 1'b1;
    @(negedge clk);
    resetCheck(0);
    runReq(0, 1'b0, 2'd0, 12'h123, 3, 12'h321, 12'h123, 1'b0);

`ifdef PSG_SKIP_UNCHANGED_EN
    runReq(1, 1'b0, 2'd2, 12'h456, 3, 12'h987, 12'h456, 1'b0);
    runReq(1, 1'b0, 2'd2, 12'h457, 1, 12'h007, 12'h007, 1'b0);
    runReq(1, 1'b0, 2'd2, 12'h457, 0, 12'h000, 12'h000, 1'b0);
`else
    runReq(1, 1'b0, 2'd2, 12'h456, 3, 12'h987, 12'h456, 1'b0);
    runReq(1, 1'b0, 2'd2, 12'h457, 3, 12'h987, 12'h457, 1'b0);
    runReq(1, 1'b0, 2'd2, 12'h457, 3, 12'h987, 12'h457, 1'b0);
`endif

    // VALID held high across back-to-back tone requests on the GAP=0 instance.
    @(negedge clk);
    snap    = strobes0;
    prevAcc = 0;
    drive(0, 1'b1, 1'b0, 2'd0, bbData[0]);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ch;
      logic [3:0] base;
      ch   = 2'(i % 3);
      base = 4'(ch) * 4'd3;
      drive(0, 1'b1, 1'b0, ch, bbData[i]);
      got = 1'b0;
      for (int t = 0; t < 50 && !got; t++) begin
        if (t != 0 || i != 0) @(negedge clk);
        if (bus0.reqReady === 1'b1) got = 1'b1;
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL b2b ready wait %0d: got ready=0 expected ready=1", i);
        break;
      end
      @(posedge clk);
      #1;
      acc = cyc;
      for (int k = 0; k < 3; k++) begin
        pushStrobe(0, 1'b0, base + 4'(k + 1), acc + 2 * k);
        pushStrobe(0, 1'b1, bbData[i][4*k +: 4], acc + 2 * k + 1);
      end
      if (i > 0) cmp($sformatf("b2b accept spacing %0d", i), acc - prevAcc, 7);
      prevAcc = acc;
    end
    drive(0, 1'b0, 1'b0, 2'd0, 12'h000);
    repeat (10) @(negedge clk);
    cmp("b2b strobe count", strobes0 - snap, 24);
    cmp("b2b pending strobes", exp0.size(), 0);
    cmp("dut1 final pending strobes", exp1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
